// File: rtl/lsu.sv
// Load/store unit: one access at a time over a req/gnt/rvalid data bus, with alignment checking.
// Latency: 3 cycles accept-to-rsp_valid with no stalls; misaligned/illegal accesses answer after 1 cycle.
// Backpressure: req_ready is low outside IDLE; bus outputs are held stable until mem_gnt.
module lsu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             mem_req,
  input  logic             mem_gnt,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic             misaligned;
  logic [3:0]       be_c;
  logic [WIDTH-1:0] wdata_c;
  logic [WIDTH-1:0] load_c;
  logic [7:0]       byte_c;
  logic [15:0]      half_c;
  logic [1:0]       off_q;
  logic [1:0]       size_q;
  logic             uns_q;

  assign req_ready = (state == IDLE);
  assign mem_req   = (state == REQ);
  assign accept    = req_valid && req_ready;

  always_comb begin
    misaligned = 1'b0;
    be_c       = 4'b1111;
    wdata_c    = req_wdata;
    case (req_size)
      2'b00: begin
        be_c    = 4'b0001 << req_addr[1:0];
        wdata_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = req_addr[0];
        be_c       = 4'b0011 << req_addr[1:0];
        wdata_c    = {2{req_wdata[15:0]}};
      end
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Lane extraction uses the offset/size captured at accept, not the live request inputs.
  always_comb begin
    case (off_q)
      2'd0:    byte_c = mem_rdata[7:0];
      2'd1:    byte_c = mem_rdata[15:8];
      2'd2:    byte_c = mem_rdata[23:16];
      default: byte_c = mem_rdata[31:24];
    endcase
    half_c = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_c = {{24{~uns_q & byte_c[7]}}, byte_c};
      2'b01:   load_c = {{16{~uns_q & half_c[15]}}, half_c};
      default: load_c = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept && !misaligned) state_nxt = REQ;
      REQ:      if (mem_gnt) state_nxt = WAIT_RSP;
      WAIT_RSP: if (mem_rvalid) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0000;
      mem_wdata <= '0;
      off_q     <= 2'b00;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      // Response fields are a single-cycle pulse and clear back to zero by default.
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      if (accept) begin
        if (misaligned) begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
        end else begin
          mem_we    <= req_we;
          mem_addr  <= {req_addr[WIDTH-1:2], 2'b00};
          mem_be    <= be_c;
          mem_wdata <= wdata_c;
          off_q     <= req_addr[1:0];
          size_q    <= req_size;
          uns_q     <= req_unsigned;
        end
      end
      if (state == WAIT_RSP && mem_rvalid) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= mem_we ? '0 : load_c;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed table-driven bench for lsu, plus hand-written grant-stall and reset-mid-access sequences.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_err = 0;

  lsu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stall;
    logic        err;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int stall, input logic err,
                              input logic [31:0] ea, input logic [3:0] ebe,
                              input logic [31:0] ewd, input logic [31:0] erd);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.stall = stall; v.err = err; v.exp_addr = ea;
    v.exp_be = ebe; v.exp_wdata = ewd; v.exp_rdata = erd;
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".req_ready"}, {31'b0, req_ready}, 32'd1);
    chk({tag, ".mem_req"},   {31'b0, mem_req},   32'd0);
    chk({tag, ".mem_we"},    {31'b0, mem_we},    32'd0);
    chk({tag, ".mem_addr"},  mem_addr,           32'd0);
    chk({tag, ".mem_be"},    {28'b0, mem_be},    32'd0);
    chk({tag, ".mem_wdata"}, mem_wdata,          32'd0);
    chk({tag, ".rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, ".rsp_err"},   {31'b0, rsp_err},   32'd0);
    chk({tag, ".rsp_rdata"}, rsp_rdata,          32'd0);
  endtask

  // Drives one access; stall cycles hold mem_gnt low and present a competing request.
  task automatic do_access(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    chk({t, ".ready_before"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (v.err) begin
      chk({t, ".err_valid"}, {31'b0, rsp_valid}, 32'd1);
      chk({t, ".err_flag"},  {31'b0, rsp_err},   32'd1);
      chk({t, ".err_rdata"}, rsp_rdata,          32'd0);
      chk({t, ".err_no_req"}, {31'b0, mem_req},  32'd0);
      chk({t, ".err_ready"}, {31'b0, req_ready}, 32'd1);
      @(posedge clk); #1;
      chk({t, ".err_pulse_end"}, {31'b0, rsp_valid}, 32'd0);
      chk({t, ".err_no_req2"}, {31'b0, mem_req},  32'd0);
    end else begin
      chk({t, ".mem_req"},  {31'b0, mem_req}, 32'd1);
      chk({t, ".mem_we"},   {31'b0, mem_we},  {31'b0, v.we});
      chk({t, ".mem_addr"}, mem_addr,         v.exp_addr);
      chk({t, ".mem_be"},   {28'b0, mem_be},  {28'b0, v.exp_be});
      if (v.we) chk({t, ".mem_wdata"}, mem_wdata, v.exp_wdata);
      chk({t, ".ready_busy"}, {31'b0, req_ready}, 32'd0);
      for (int i = 0; i < v.stall; i++) begin
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
        req_addr = 32'hFFFF_0000; req_wdata = 32'h5555_5555;
        @(posedge clk); #1;
        chk({t, ".stall_req"},   {31'b0, mem_req}, 32'd1);
        chk({t, ".stall_addr"},  mem_addr,         v.exp_addr);
        chk({t, ".stall_be"},    {28'b0, mem_be},  {28'b0, v.exp_be});
        chk({t, ".stall_we"},    {31'b0, mem_we},  {31'b0, v.we});
        if (v.we) chk({t, ".stall_wdata"}, mem_wdata, v.exp_wdata);
        chk({t, ".stall_ready"}, {31'b0, req_ready}, 32'd0);
      end
      req_valid = 1'b0;
      mem_gnt = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata = 32'hBAD0_BAD0;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      chk({t, ".wait_no_req"}, {31'b0, mem_req},   32'd0);
      chk({t, ".wait_no_rsp"}, {31'b0, rsp_valid}, 32'd0);
      mem_rvalid = 1'b1; mem_rdata = v.rdata;
      @(posedge clk); #1;
      mem_rvalid = 1'b0; mem_rdata = 32'hBAD0_BAD0;
      chk({t, ".rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
      chk({t, ".rsp_err"},   {31'b0, rsp_err},   32'd0);
      chk({t, ".rsp_rdata"}, rsp_rdata,          v.exp_rdata);
      chk({t, ".rsp_ready"}, {31'b0, req_ready}, 32'd1);
      @(posedge clk); #1;
      chk({t, ".pulse_end"}, {31'b0, rsp_valid}, 32'd0);
      chk({t, ".rdata_clr"}, rsp_rdata,          32'd0);
      chk({t, ".no_second"}, {31'b0, mem_req},   32'd0);
    end
  endtask

  initial begin
    //            we    sz     u     addr          wdata         rdata         st err  exp_addr      be       exp_wdata     exp_rdata
    vecs[0]  = mk(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0,        32'h80AB_CDEF, 0, 1'b0, 32'h0000_1000, 4'b1000, 32'h0,        32'hFFFF_FF80);
    vecs[1]  = mk(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 0, 1'b0, 32'h0000_2000, 4'b1100, 32'h0,        32'h0000_BEEF);
    vecs[2]  = mk(1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_00A5, 32'hDEAD_BEEF, 0, 1'b0, 32'h0000_0010, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    vecs[3]  = mk(1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0);
    vecs[4]  = mk(1'b0, 2'b01, 1'b0, 32'h0000_2000, 32'h0,        32'h0000_8001, 3, 1'b0, 32'h0000_2000, 4'b0011, 32'h0,        32'hFFFF_8001);
    vecs[5]  = mk(1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'h1234_ABCD, 32'h0,        0, 1'b0, 32'h0000_0004, 4'b1100, 32'hABCD_ABCD, 32'h0);
    vecs[6]  = mk(1'b0, 2'b00, 1'b1, 32'h0000_0001, 32'h0,        32'h0000_F000, 0, 1'b0, 32'h0000_0000, 4'b0010, 32'h0,        32'h0000_00F0);
    vecs[7]  = mk(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0);
    vecs[8]  = mk(1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0);
    vecs[9]  = mk(1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'hCAFE_F00D, 32'h1111_1111, 2, 1'b0, 32'h0000_0008, 4'b1111, 32'hCAFE_F00D, 32'h0);
    vecs[10] = mk(1'b0, 2'b10, 1'b1, 32'h0000_000C, 32'h0,        32'h8765_4321, 0, 1'b0, 32'h0000_000C, 4'b1111, 32'h0,        32'h8765_4321);
    vecs[11] = mk(1'b0, 2'b00, 1'b0, 32'h0000_0002, 32'h0,        32'h007F_0000, 0, 1'b0, 32'h0000_0000, 4'b0100, 32'h0,        32'h0000_007F);
    vecs[12] = mk(1'b1, 2'b10, 1'b0, 32'h0000_0001, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0);

    #12;
    check_reset_outputs("reset");
    mem_rvalid = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); mem_rvalid = 1'b0;
    @(negedge clk);
    chk("stale_rvalid_rsp", {31'b0, rsp_valid}, 32'd0);
    chk("stale_rvalid_req", {31'b0, mem_req},   32'd0);

    for (int i = 0; i < 13; i++) do_access(i, vecs[i]);

    // Reset while waiting for a response: the access is abandoned and a late rvalid is ignored.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h40; req_unsigned = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    chk("rst_mid.in_wait", {31'b0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk); rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("rst_mid.no_rsp", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    check_reset_outputs("rst_after");
    do_access(99, mk(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h1234_5678, 0, 1'b0,
                     32'h0, 4'b1111, 32'h0, 32'h1234_5678));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the lx32 core, directly downstream of the ALU. It takes the effective address the ALU computes (rs1 + imm) together with the store data and access type from execute. It runs one access at a time over a request/grant/response data-memory bus. It returns either a size- and sign-adjusted load result for writeback or an alignment error.

## Interface
- `WIDTH`, 32: data and address width. Only 32 is supported.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: execute presents an access.
- `req_ready` out 1: LSU can accept; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: zero-extend loads (LBU/LHU); ignored for word and for stores.
- `req_addr` in WIDTH: effective byte address (ALU result).
- `req_wdata` in WIDTH: store data (rs2).
- `mem_req` out 1: bus request.
- `mem_gnt` in 1: bus accepted the request this cycle.
- `mem_we` out 1: write enable.
- `mem_addr` out WIDTH: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out WIDTH: lane-replicated store data.
- `mem_rvalid` in 1: response valid.
- `mem_rdata` in WIDTH: read data (word).
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out WIDTH: extended load data; 0 for stores and errors.
- `rsp_err` out 1: misaligned or illegal access, qualified by `rsp_valid`.

## Operation
- **States:** IDLE, REQ, WAIT_RSP.
- **Accept:** a request is accepted on `req_valid && req_ready` in IDLE. The LSU latches addr, size, unsigned, we and wdata.
- **Alignment check on accept:**
  - Error if half with `addr[0]=1`, word with `addr[1:0]!=0`, or size 11.
  - On error: stay in IDLE, drive no `mem_req`, and register `rsp_valid=1`, `rsp_err=1`, `rsp_rdata=0` for the next cycle.
- **Legal access:** go to REQ.
- **REQ:** `mem_req=1`. `mem_we/addr/be/wdata` are driven from registers and held stable until `mem_gnt`. On `mem_gnt`, go to WAIT_RSP. `mem_rvalid` is ignored in REQ.
- **WAIT_RSP:** `mem_req=0`. On `mem_rvalid`, go to IDLE and register the response. Stores also wait for `mem_rvalid`.
- **Byte enables:** byte `4'b0001 << addr[1:0]`; half `4'b0011 << addr[1:0]`; word `4'b1111`.
- **Store data:** byte `{4{wdata[7:0]}}`; half `{2{wdata[15:0]}}`; word unchanged.
- **Load data:**
  - Byte: `(rdata >> 8*addr[1:0])[7:0]`.
  - Half: `addr[1] ? rdata[31:16] : rdata[15:0]`.
  - Sign-extended unless `req_unsigned`. Word is passed through.
- **Outstanding accesses:** one at a time. A new request can be accepted in the same cycle that `rsp_valid` pulses.
- **Stale responses:** `mem_rvalid` in IDLE (e.g. after a reset) is ignored.

## Timing
- **Reset values:** state IDLE; `req_ready=1`; `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_be=0`, `mem_wdata=0`; `rsp_valid=0`, `rsp_err=0`, `rsp_rdata=0`.
- **Best case:** accept at cycle T, `mem_req` high at T+1, `mem_gnt` at T+1, `mem_rvalid` no earlier than T+2, `rsp_valid` at T+3. Each grant or response stall cycle adds one cycle.
- **Error case:** `rsp_valid` with `rsp_err=1` at T+1.
- **Response pulse:** `rsp_valid` is high for exactly one cycle. `rsp_rdata` and `rsp_err` are valid only during that cycle and return to 0 afterward.
- **Handshake:** `req_ready` is combinational from state (high only in IDLE). The bus must never see `mem_req` deasserted before `mem_gnt` except on reset.
- **Reset mid-operation:** `rst_n` low forces all outputs to reset values immediately, and the in-flight access is abandoned.

## Test plan
- **Signed byte load:** LB at 0x1003, `mem_rdata=0x80AB_CDEF` -> `mem_addr=0x1000`, `mem_be=4'b1000`, `rsp_rdata=0xFFFF_FF80`, `rsp_err=0`, `rsp_valid` at T+3 with zero stalls.
- **Unsigned half load:** LHU at 0x2002, `mem_rdata=0xBEEF_1234` -> `rsp_rdata=0x0000_BEEF`.
- **Byte store:** SB at 0x11, `wdata=0x0000_00A5` -> `mem_we=1`, `mem_addr=0x10`, `mem_be=4'b0010`, `mem_wdata=0xA5A5_A5A5`. `rsp_rdata=0` after `mem_rvalid`.
- **Misaligned word load:** LW at 0x102 -> no `mem_req` ever. `rsp_valid=1`, `rsp_err=1` at T+1. `req_ready` stays 1.
- **Grant stall:** `mem_gnt` held low 3 cycles -> `mem_req/addr/be/wdata` stable all 4 cycles. `req_ready=0`, and a second `req_valid` is not accepted. Response follows normally.
- **Reset mid-access:** assert `rst_n=0` in WAIT_RSP, release, then pulse `mem_rvalid` -> no `rsp_valid`. Outputs hold reset values. A fresh LW at 0x0 with `rdata=0x1234_5678` then returns 0x1234_5678.
